rv_mem_arbiter: RTL

- Shares one single-port synchronous word memory (1-cycle read latency) between the CPU instruction-fetch port and the load/store port of the easyrv core.
- Arbitrates between the two ports, sequences each access through a 4-state FSM, and returns registered read data with a one-cycle ack pulse.
- Data port has priority. A streak limit guarantees fetch cannot be starved.

---
 rtl/rv_mem_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/rv_mem_arbiter.sv
// Two-port arbiter that shares one 1-cycle-latency synchronous word memory between instruction fetch and load/store.
// Data wins ties; a streak counter lets fetch through after MAX_D_STREAK back-to-back data grants.
module rv_mem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic [3:0]        d_wstrb,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic              grant_d
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_streak;
    logic              r_is_wr;
    logic              r_mem_en;
    logic [3:0]        r_mem_we;
    logic [ADDR_W-3:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_i_ack;
    logic              r_d_ack;
    logic [31:0]       r_i_rdata;
    logic [31:0]       r_d_rdata;
    logic              r_grant_d;
    logic              w_grant;
    logic              w_pick_d;
    logic              w_busy;

    // Fetch only beats a waiting data request once the data streak has hit its limit.
    assign w_grant  = (r_state == S_IDLE) && (i_req || d_req);
    assign w_pick_d = d_req && !(i_req && (r_streak == 4'(MAX_D_STREAK)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_grant) w_next = S_ACCESS;
            S_ACCESS: w_next = S_WAIT;
            S_WAIT:   w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_streak    <= '0;
            r_is_wr     <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_grant_d   <= 1'b0;
        end else begin
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_mem_en   <= 1'b1;
                        r_grant_d  <= w_pick_d;
                        r_is_wr    <= w_pick_d && d_we;
                        r_mem_addr <= w_pick_d ? d_addr[ADDR_W-1:2] : i_addr[ADDR_W-1:2];
                        r_streak   <= (w_pick_d && i_req) ? r_streak + 4'd1 : 4'd0;
                        if (w_pick_d && d_we) begin
                            r_mem_we    <= d_wstrb;
                            r_mem_wdata <= d_wdata;
                        end else begin
                            r_mem_we <= '0;
                        end
                    end
                end
                S_ACCESS: begin
                    r_mem_en <= 1'b0;
                    r_mem_we <= '0;
                end
                S_WAIT: begin
                    // Stores complete with an ack but leave the load-data register alone.
                    if (r_grant_d) begin
                        r_d_ack <= 1'b1;
                        if (!r_is_wr) r_d_rdata <= mem_rdata;
                    end else begin
                        r_i_ack   <= 1'b1;
                        r_i_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign i_ack     = r_i_ack;
    assign i_rdata   = r_i_rdata;
    assign d_ack     = r_d_ack;
    assign d_rdata   = r_d_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = w_busy;
    assign grant_d   = r_grant_d;
endmodule
